// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//
// Control partner for the clock PLL wrapper. Drives the PLL reset pulse, waits
// for the PLL locked flag, insists that lock stays up for a stable interval,
// and only then releases the synchronous system reset for the downstream
// carrier and DSP domains. Lock timeouts trigger a fresh PLL reset (retry);
// a lock loss while running drops the system back into reset and re-sequences.
//
// Everything runs on refclk because the PLL output clocks cannot be trusted
// while the PLL is unlocked.
//
// Ports:
//   refclk     in   50 MHz reference clock, rising edge only
//   rst        in   synchronous active-high reset
//   pll_locked in   PLL locked flag, asynchronous to refclk
//   pll_rst    out  PLL reset, active-high, registered
//   sys_rst    out  downstream synchronous reset, active-high, registered
//   ready      out  high only while in RUN, registered
//   state      out  FSM state: 0 RESET_PLL, 1 WAIT_LOCK, 2 STABLE, 3 RUN
//   retry_cnt  out  number of WAIT_LOCK timeouts, saturating at 255
//   loss_cnt   out  number of lock losses seen in RUN, saturating at 255
//
// There is no valid/ready handshake on this block: ready is a level status
// flag that is high exactly while sys_rst is low.
// -----------------------------------------------------------------------------
module pll_lock_sequencer #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int CNT_W            = 16
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    typedef enum logic [1:0] {
        S_RESET_PLL = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    // Counter load values: each phase counts down to zero, so the load is
    // one less than the number of cycles the phase should last.
    localparam logic [CNT_W-1:0] RST_LOAD     = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [7:0]       SAT_MAX      = 8'hFF;

    state_t           state_q;
    state_t           state_n;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_n;
    logic             retry_inc;
    logic             loss_inc;
    logic             cnt_zero;

    // Two-flop synchronizer for the asynchronous lock flag.
    logic             lock_meta;
    logic             lock_s;

    assign cnt_zero = (cnt_q == '0);
    assign state    = state_q;

    // Next-state and counter logic.
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        retry_inc = 1'b0;
        loss_inc  = 1'b0;

        case (state_q)
            S_RESET_PLL: begin
                if (cnt_zero) begin
                    state_n = S_WAIT_LOCK;
                    cnt_n   = TIMEOUT_LOAD;
                end else begin
                    cnt_n = cnt_q - CNT_ONE;
                end
            end

            S_WAIT_LOCK: begin
                // Lock is checked first so a lock arriving on the final
                // timeout cycle is not thrown away by a needless retry.
                if (lock_s) begin
                    state_n = S_STABLE;
                    cnt_n   = STABLE_LOAD;
                end else if (cnt_zero) begin
                    state_n   = S_RESET_PLL;
                    cnt_n     = RST_LOAD;
                    retry_inc = 1'b1;
                end else begin
                    cnt_n = cnt_q - CNT_ONE;
                end
            end

            S_STABLE: begin
                // A dropout during qualification just restarts the wait for
                // lock; it is neither a retry nor a loss.
                if (!lock_s) begin
                    state_n = S_WAIT_LOCK;
                    cnt_n   = TIMEOUT_LOAD;
                end else if (cnt_zero) begin
                    state_n = S_RUN;
                end else begin
                    cnt_n = cnt_q - CNT_ONE;
                end
            end

            S_RUN: begin
                if (!lock_s) begin
                    state_n  = S_RESET_PLL;
                    cnt_n    = RST_LOAD;
                    loss_inc = 1'b1;
                end
            end

            default: begin
                state_n = S_RESET_PLL;
                cnt_n   = RST_LOAD;
            end
        endcase
    end

    // State, counter, synchronizer and registered outputs. Outputs are
    // decoded from the next state so they change on the same edge as state.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= S_RESET_PLL;
            cnt_q     <= RST_LOAD;
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            retry_cnt <= 8'd0;
            loss_cnt  <= 8'd0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            pll_rst   <= (state_n == S_RESET_PLL);
            sys_rst   <= (state_n != S_RUN);
            ready     <= (state_n == S_RUN);
            if (retry_inc && (retry_cnt != SAT_MAX)) begin
                retry_cnt <= retry_cnt + 8'd1;
            end
            if (loss_inc && (loss_cnt != SAT_MAX)) begin
                loss_cnt <= loss_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_sequencer
//
// Bench for pll_lock_sequencer with short parameters (4 / 8 / 32). A table of
// hand-computed vectors walks power-up, clean lock, lock loss and a STABLE
// glitch; hand-written sequences cover retry saturation and mid-operation
// reset; random pll_locked/rst stimulus runs against a phase/age reference
// model whose per-cycle predictions go through an expected-value queue.
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

    localparam int RST_PULSE_CYC    = 4;
    localparam int LOCK_STABLE_CYC  = 8;
    localparam int LOCK_TIMEOUT_CYC = 32;
    localparam int W                = 21;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [1:0] state;
    logic [7:0] retry_cnt;
    logic [7:0] loss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pll_lock_sequencer #(
        .RST_PULSE_CYC   (RST_PULSE_CYC),
        .LOCK_STABLE_CYC (LOCK_STABLE_CYC),
        .LOCK_TIMEOUT_CYC(LOCK_TIMEOUT_CYC),
        .CNT_W           (16)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .state     (state),
        .retry_cnt (retry_cnt),
        .loss_cnt  (loss_cnt)
    );

    // ---------------- clock / reset ----------------
    initial begin
        refclk = 1'b0;
        forever #10 refclk = ~refclk;
    end

    // ---------------- comparison helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Phases: 0 pulse, 1 waiting for lock, 2 qualifying, 3 running.
    // m_age is the number of cycles already spent in the current phase.
    int         m_phase;
    int         m_age;
    int         m_retry;
    int         m_loss;
    logic       m_hist1;
    logic       m_hist2;
    logic       m_valid = 1'b0;
    logic       lock_seen;
    logic [W-1:0] exp_q[$];

    always @(posedge refclk) begin
        if (rst) begin
            m_phase = 0; m_age = 0; m_retry = 0; m_loss = 0;
            m_hist1 = 1'b0; m_hist2 = 1'b0; m_valid = 1'b1;
        end else if (m_valid) begin
            // The FSM acts on the lock level captured two edges ago.
            lock_seen = m_hist2;
            m_hist2   = m_hist1;
            m_hist1   = pll_locked;
            case (m_phase)
                0: if (m_age == RST_PULSE_CYC - 1) begin m_phase = 1; m_age = 0; end
                   else m_age++;
                1: if (lock_seen) begin m_phase = 2; m_age = 0; end
                   else if (m_age == LOCK_TIMEOUT_CYC - 1) begin
                       m_phase = 0; m_age = 0;
                       if (m_retry < 255) m_retry++;
                   end else m_age++;
                2: if (!lock_seen) begin m_phase = 1; m_age = 0; end
                   else if (m_age == LOCK_STABLE_CYC - 1) begin m_phase = 3; m_age = 0; end
                   else m_age++;
                default: if (!lock_seen) begin
                       m_phase = 0; m_age = 0;
                       if (m_loss < 255) m_loss++;
                   end
            endcase
        end
        if (m_valid) begin
            exp_q.push_back({2'(m_phase), m_phase == 0, m_phase != 3, m_phase == 3,
                             8'(m_retry), 8'(m_loss)});
        end
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_v;
    always @(negedge refclk) begin
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            chk("model", 32'({state, pll_rst, sys_rst, ready, retry_cnt, loss_cnt}), 32'(exp_v));
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; applies inputs, runs n rising edges, returns at
    // the following negedge.
    task automatic drive(input logic r, input logic l, input int n);
        rst        = r;
        pll_locked = l;
        repeat (n) @(posedge refclk);
        @(negedge refclk);
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget);
        int k;
        k = 0;
        while (state !== s && k < budget) begin
            @(negedge refclk);
            k++;
        end
        chk("wait_state", 32'(state), 32'(s));
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic prst,
                           input logic srst, input logic rdy, input logic [7:0] rc,
                           input logic [7:0] lc);
        chk({tag, ".state"},     32'(state),     32'(st));
        chk({tag, ".pll_rst"},   32'(pll_rst),   32'(prst));
        chk({tag, ".sys_rst"},   32'(sys_rst),   32'(srst));
        chk({tag, ".ready"},     32'(ready),     32'(rdy));
        chk({tag, ".retry_cnt"}, 32'(retry_cnt), 32'(rc));
        chk({tag, ".loss_cnt"},  32'(loss_cnt),  32'(lc));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       r;
        logic       l;
        int         n;
        logic [1:0] st;
        logic       prst;
        logic       srst;
        logic       rdy;
        logic [7:0] rc;
        logic [7:0] lc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic l, input int n, input logic [1:0] st,
                                input logic prst, input logic srst, input logic rdy,
                                input logic [7:0] rc, input logic [7:0] lc);
        vec_t v;
        v.r = r; v.l = l; v.n = n; v.st = st; v.prst = prst; v.srst = srst;
        v.rdy = rdy; v.rc = rc; v.lc = lc;
        return v;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
        @(negedge refclk);

        // Power-up: reset edge e0, pulse through e3, WAIT_LOCK from e4.
        vecs.push_back(mk(1, 0, 1, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 0, 0));
        // Clean lock: rise sampled at e14 gives STABLE at e16, RUN at e24.
        vecs.push_back(mk(0, 0, 9, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 2, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 7, 2, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 3, 0, 0, 1, 0, 0));
        // Loss in RUN: fall sampled at e25 gives reset at e27.
        vecs.push_back(mk(0, 0, 1, 3, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 3, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 3, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 0, 1));
        // Re-lock, then a one-cycle dropout while qualifying.
        vecs.push_back(mk(0, 1, 1, 1, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 2, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 2, 2, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 2, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 2, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 0, 1, 0, 0, 1));
        // Full qualification restarts: STABLE at e40, RUN only at e48.
        vecs.push_back(mk(0, 1, 1, 2, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 7, 2, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 3, 0, 0, 1, 0, 1));
        // Reset while running clears everything.
        vecs.push_back(mk(1, 1, 1, 0, 1, 1, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].l, vecs[i].n);
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].prst, vecs[i].srst,
                    vecs[i].rdy, vecs[i].rc, vecs[i].lc);
        end

        // No lock: one retry every 36 cycles, saturating at 255.
        drive(1, 0, 1);
        drive(0, 0, 35);
        chk_all("nolock_pre", 1, 0, 1, 0, 0, 0);
        drive(0, 0, 1);
        chk_all("nolock_r1", 0, 1, 1, 0, 1, 0);
        for (int i = 2; i <= 3; i++) begin
            drive(0, 0, 36);
            chk($sformatf("nolock_r%0d", i), 32'(retry_cnt), 32'(i));
        end
        drive(0, 0, 36 * 297);
        chk("nolock_sat", 32'(retry_cnt), 32'd255);

        // Reset during STABLE.
        pll_locked = 1'b1;
        wait_state(2'd2, 100);
        drive(1, 1, 1);
        chk_all("rst_stable", 0, 1, 1, 0, 0, 0);

        // Three losses in RUN, then reset during RUN.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pll_locked = 1'b1;
            wait_state(2'd3, 100);
            pll_locked = 1'b0;
            wait_state(2'd0, 10);
        end
        pll_locked = 1'b1;
        wait_state(2'd3, 100);
        chk("loss3", 32'(loss_cnt), 32'd3);
        drive(1, 1, 1);
        chk_all("rst_run", 0, 1, 1, 0, 0, 0);

        // Random lock activity with occasional resets, checked by the model.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                drive(1, 1'($urandom_range(0, 1)), 1);
            end else begin
                drive(0, 1'($urandom_range(0, 1)), $urandom_range(1, 45));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
